// File: rtl/run_controller.sv
// Sequences NUM_PROGS programs on an attached processor: an init/restart pulse for each,
// then a timed RUN phase, with per-program timeout flags.
module run_controller #(
    parameter int unsigned NUM_PROGS   = 4,
    parameter int unsigned INIT_CYCLES = 2,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned MAX_CYCLES  = 1000,
    localparam int unsigned PID_W      = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1
) (
    input  logic             clock,
    input  logic             init_n,
    input  logic             start,
    input  logic             abort,
    input  logic             proc_done,
    output logic             proc_init,
    output logic             proc_restart,
    output logic [PID_W-1:0] prog_id,
    output logic             busy,
    output logic             all_done,
    output logic [CNT_W-1:0] cycle_count,
    output logic [NUM_PROGS-1:0] fail_mask
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        RUN  = 3'd2,
        NEXT = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] MAX_C      = CNT_W'(MAX_CYCLES);
    localparam logic [7:0]       LOAD_LAST  = 8'(INIT_CYCLES - 1);
    localparam logic [PID_W-1:0] PID_LAST   = PID_W'(NUM_PROGS - 1);

    state_t               state_q, state_d;
    logic [7:0]           load_cnt_q, load_cnt_d;
    logic [CNT_W-1:0]     run_cnt_q, run_cnt_d;
    logic [PID_W-1:0]     prog_id_q, prog_id_d;
    logic [CNT_W-1:0]     cycle_count_q, cycle_count_d;
    logic [NUM_PROGS-1:0] fail_mask_q, fail_mask_d;
    logic [CNT_W-1:0]     run_inc;

    assign run_inc = run_cnt_q + CNT_W'(1);

    always_ff @(posedge clock or negedge init_n) begin
        if (!init_n) begin
            state_q       <= IDLE;
            load_cnt_q    <= '0;
            run_cnt_q     <= '0;
            prog_id_q     <= '0;
            cycle_count_q <= '0;
            fail_mask_q   <= '0;
        end else begin
            state_q       <= state_d;
            load_cnt_q    <= load_cnt_d;
            run_cnt_q     <= run_cnt_d;
            prog_id_q     <= prog_id_d;
            cycle_count_q <= cycle_count_d;
            fail_mask_q   <= fail_mask_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        load_cnt_d    = load_cnt_q;
        run_cnt_d     = run_cnt_q;
        prog_id_d     = prog_id_q;
        cycle_count_d = cycle_count_q;
        fail_mask_d   = fail_mask_q;

        // abort is checked first so a same-cycle completion or timeout cannot touch the results
        if (abort) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_d     = LOAD;
                        load_cnt_d  = '0;
                        prog_id_d   = '0;
                        fail_mask_d = '0;
                    end
                end
                LOAD: begin
                    if (load_cnt_q == LOAD_LAST) begin
                        state_d   = RUN;
                        run_cnt_d = '0;
                    end else begin
                        load_cnt_d = load_cnt_q + 8'd1;
                    end
                end
                RUN: begin
                    if (proc_done) begin
                        cycle_count_d = run_inc;
                        state_d       = NEXT;
                    end else if (run_inc == MAX_C) begin
                        fail_mask_d[prog_id_q] = 1'b1;
                        cycle_count_d          = MAX_C;
                        state_d                = NEXT;
                    end else begin
                        run_cnt_d = run_inc;
                    end
                end
                NEXT: begin
                    if (prog_id_q == PID_LAST) begin
                        state_d = DONE;
                    end else begin
                        prog_id_d  = prog_id_q + PID_W'(1);
                        load_cnt_d = '0;
                        state_d    = LOAD;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign proc_init    = (state_q == LOAD) && (prog_id_q == '0);
    assign proc_restart = (state_q == LOAD) && (prog_id_q != '0);
    assign busy         = (state_q == LOAD) || (state_q == RUN) || (state_q == NEXT);
    assign all_done     = (state_q == DONE);
    assign prog_id      = prog_id_q;
    assign cycle_count  = cycle_count_q;
    assign fail_mask    = fail_mask_q;

endmodule

// File: doc/run_controller.md
RUN_CONTROLLER -- requirements
Module: run_controller

Interface
REQ-001 Parameter NUM_PROGS, default 4, number of programs run back-to-back per sequence (1..16).
REQ-002 Parameter INIT_CYCLES, default 2, length in cycles of each proc_init/proc_restart pulse (1..255).
REQ-003 Parameter CNT_W, default 16, width of the run-cycle counter.
REQ-004 Parameter MAX_CYCLES, default 1000, per-program timeout limit in RUN cycles (1..2^CNT_W-1).
REQ-005 Port clock  in  1  single clock; all state updates on rising edge.
REQ-006 Port init_n  in  1  reset, asynchronous, active-low.
REQ-007 Port start  in  1  begins a sequence when sampled high in IDLE or DONE.
REQ-008 Port abort  in  1  forces return to IDLE from any state.
REQ-009 Port proc_done  in  1  done flag from the processor under control.
REQ-010 Port proc_init  out  1  init pulse to processor.
REQ-011 Port proc_restart  out  1  restart pulse to processor.
REQ-012 Port prog_id  out  clog2(NUM_PROGS) (min 1)  index of current program.
REQ-013 Port busy  out  1  high in LOAD, RUN, NEXT.
REQ-014 Port all_done  out  1  high in DONE.
REQ-015 Port cycle_count  out  CNT_W  RUN-cycle count of the most recently completed program.
REQ-016 Port fail_mask  out  NUM_PROGS  bit i set when program i timed out.

Function
REQ-017 States IDLE, LOAD, RUN, NEXT, DONE in a registered state variable; all outputs are decoded from registers only; no combinational input-to-output path.
REQ-018 IDLE: proc_init=proc_restart=busy=all_done=0; start=1 -> LOAD with prog_id=0, fail_mask cleared, cycle_count retained.
REQ-019 LOAD: lasts exactly INIT_CYCLES cycles; proc_init=1 when prog_id=0, else proc_restart=1 (never both); then -> RUN.
REQ-020 RUN: internal run counter starts at 0 on entry and increments every RUN cycle; proc_done sampled high -> cycle_count <= run counter + 1, -> NEXT.
REQ-021 RUN timeout: run counter + 1 = MAX_CYCLES with proc_done=0 -> fail_mask[prog_id] <= 1, cycle_count <= MAX_CYCLES, -> NEXT.
REQ-022 proc_done and timeout on the same cycle: proc_done wins; no fail bit set.
REQ-023 NEXT: one cycle; prog_id = NUM_PROGS-1 -> DONE, else prog_id increments -> LOAD.
REQ-024 DONE: all_done=1 held, prog_id holds last value; start=1 -> LOAD with prog_id=0 and fail_mask cleared.
REQ-025 start is ignored in LOAD, RUN, NEXT; proc_done is ignored outside RUN.
REQ-026 abort=1 in any state -> IDLE next cycle, proc_init/proc_restart drop that edge; fail_mask and cycle_count retained; abort beats start on the same cycle.
REQ-027 Run counter does not wrap: MAX_CYCLES bounds it below 2^CNT_W.

Reset
REQ-028 init_n=0 asynchronously forces IDLE, prog_id=0, cycle_count=0, fail_mask=0, all outputs 0, regardless of clock.
REQ-029 Reset asserted mid-RUN or mid-LOAD drops proc_init/proc_restart immediately; after init_n rises, no activity until start.

Verification (NUM_PROGS=3, INIT_CYCLES=2, MAX_CYCLES=100, CNT_W=16)
REQ-030 start pulse, processor raises proc_done after 10 RUN cycles for each program -> proc_init 2 cycles (prog 0), proc_restart 2 cycles (progs 1,2), cycle_count=10 each, all_done=1, fail_mask=3'b000.
REQ-031 prog 1 never raises proc_done -> cycle_count=100 after prog 1, fail_mask=3'b010, sequence continues to prog 2 and DONE.
REQ-032 proc_done high exactly on RUN cycle 100 -> pass, cycle_count=100, fail_mask bit clear.
REQ-033 abort during RUN of prog 1 -> IDLE next cycle, busy=0, prog_id=0 is not required but fail_mask unchanged; later start restarts from prog 0 with proc_init.
REQ-034 init_n pulsed low mid-LOAD -> proc_init falls without a clock edge, all outputs 0; start during DONE re-runs sequence with fail_mask cleared.
